// File: rtl/dcollide_object_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcollide_object_loader
// Function : Pulses the address controller, samples each memory word RD_LAT
//            cycles later and packs WORDS_PER_OBJ words into object records
//            handed to the collision core over a valid/ready handshake.
// Option   : define DCOLLIDE_LOADER_PREFETCH_EN for a separate assembly register
// Revision : 1.0 - initial release
// ============================================================================
module dcollide_object_loader #(
  parameter int DATA_W        = 32,
  parameter int WORDS_PER_OBJ = 4,
  parameter int RD_LAT        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DATA_W-1:0]               mem_data,
  input  logic                            end_of_memory,
  output logic                            fetch_data_ready,
  output logic                            obj_valid,
  input  logic                            obj_ready,
  output logic [DATA_W*WORDS_PER_OBJ-1:0] obj_data,
  output logic [15:0]                     obj_index,
  output logic                            partial_obj,
  output logic                            done
);

  localparam int                    c_OBJ_W   = DATA_W * WORDS_PER_OBJ;
  localparam int                    c_WCNT_W  = (WORDS_PER_OBJ > 1) ? $clog2(WORDS_PER_OBJ) : 1;
  localparam logic [c_WCNT_W-1:0]   c_LAST    = c_WCNT_W'(WORDS_PER_OBJ - 1);
  localparam logic [2:0]            c_LAT_END = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4,
    S_FLUSH   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                r_state, w_next;
  logic [c_WCNT_W-1:0]   r_wcnt;
  logic [2:0]            r_lat;
  logic                  r_fdr, r_valid, r_partial, r_done;
  logic [c_OBJ_W-1:0]    r_obj_data, w_asm_base, w_asm_next;
  logic [15:0]           r_index;
  logic                  w_wr_word, w_load, w_drop;
  logic                  w_xfer, w_out_free, w_last;

  assign w_xfer     = r_valid && obj_ready;
  assign w_out_free = !r_valid || obj_ready;
  assign w_last     = (r_wcnt == c_LAST);

`ifdef DCOLLIDE_LOADER_PREFETCH_EN
  logic [c_OBJ_W-1:0] r_asm;
  assign w_asm_base = r_asm;
`else
  // Without prefetch the output register doubles as the assembly buffer.
  assign w_asm_base = r_obj_data;
`endif

  always_comb begin
    w_asm_next = w_asm_base;
    if (w_wr_word) w_asm_next[int'(r_wcnt)*DATA_W +: DATA_W] = mem_data;
  end

  always_comb begin
    w_next    = r_state;
    w_wr_word = 1'b0;
    w_load    = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PULSE;
      S_PULSE: w_next = S_WAIT;
      S_WAIT:  if (r_lat == c_LAT_END) w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (end_of_memory) begin
          w_drop = 1'b1;
          w_next = S_FLUSH;
        end else begin
          w_wr_word = 1'b1;
          if (!w_last) begin
            w_next = S_PULSE;
`ifdef DCOLLIDE_LOADER_PREFETCH_EN
          end else if (w_out_free) begin
            w_load = 1'b1;
            w_next = S_PULSE;
          end else begin
            w_next = S_HOLD;
          end
`else
          end else begin
            w_load = 1'b1;
            w_next = S_HOLD;
          end
`endif
        end
      end
      S_HOLD: begin
        if (w_out_free) begin
`ifdef DCOLLIDE_LOADER_PREFETCH_EN
          w_load = 1'b1;
`endif
          w_next = S_PULSE;
        end
      end
      S_FLUSH: if (!r_valid) w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fdr      <= 1'b0;
      r_lat      <= 3'd0;
      r_wcnt     <= '0;
      r_valid    <= 1'b0;
      r_partial  <= 1'b0;
      r_done     <= 1'b0;
      r_obj_data <= '0;
      r_index    <= 16'd0;
`ifdef DCOLLIDE_LOADER_PREFETCH_EN
      r_asm      <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_fdr   <= (w_next == S_PULSE);
      r_lat   <= (r_state == S_WAIT) ? r_lat + 3'd1 : 3'd0;
      if (w_drop) begin
        r_wcnt <= '0;
        if (r_wcnt != '0) r_partial <= 1'b1;
      end else if (w_wr_word) begin
        r_wcnt <= w_last ? '0 : r_wcnt + c_WCNT_W'(1);
      end
      // A load in the same cycle as a transfer keeps valid high with the new record.
      if (w_load)      r_valid <= 1'b1;
      else if (w_xfer) r_valid <= 1'b0;
      if (w_xfer) r_index <= r_index + 16'd1;
      if (r_state == S_FLUSH && !r_valid) r_done <= 1'b1;
`ifdef DCOLLIDE_LOADER_PREFETCH_EN
      if (w_wr_word) r_asm      <= w_asm_next;
      if (w_load)    r_obj_data <= w_asm_next;
`else
      if (w_wr_word) r_obj_data <= w_asm_next;
`endif
    end
  end

  assign fetch_data_ready = r_fdr;
  assign obj_valid        = r_valid;
  assign obj_data         = r_obj_data;
  assign obj_index        = r_index;
  assign partial_obj      = r_partial;
  assign done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dcollide_object_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcollide_object_loader
// Function : Three loader instances (W/RD_LAT = 4/2, 5/1, 4/7) fed by a shared
//            memory image through per-instance address-controller models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcollide_object_loader;

  localparam int NI   = 3;
  localparam int MAXW = 160;
  localparam logic [2:0][7:0] WA = {8'd4, 8'd5, 8'd4};
  localparam logic [2:0][7:0] LA = {8'd7, 8'd1, 8'd2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic obj_ready = 1'b0;
  logic [31:0]     md  [NI];
  logic            eom [NI];
  logic [NI-1:0]   fdr, ov, pobj, dn;
  logic [MAXW-1:0] od  [NI];
  logic [15:0]     oi  [NI];

  logic [31:0] mem [64];
  int nmem = 0;
  bit chk_gap = 1'b0;
  int checks = 0;
  int failures = 0;

  initial forever #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [32*int'(WA[gi])-1:0] w_od;
    dcollide_object_loader #(
      .DATA_W(32), .WORDS_PER_OBJ(int'(WA[gi])), .RD_LAT(int'(LA[gi]))
    ) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_data(md[gi]), .end_of_memory(eom[gi]),
      .fetch_data_ready(fdr[gi]), .obj_valid(ov[gi]), .obj_ready(obj_ready),
      .obj_data(w_od), .obj_index(oi[gi]),
      .partial_obj(pobj[gi]), .done(dn[gi])
    );
    assign od[gi] = MAXW'(w_od);
  end

  // Address-controller model: first pulse primes, later pulses advance.
  int addr [NI];
  bit primed [NI];
  int since [NI];
  int pulses [NI];
  int last_pulse [NI];
  int gap_bad [NI];
  int hold_err [NI];
  int stall_pulse [NI];
  bit prev_stall [NI];
  logic [MAXW-1:0] prev_od [NI];
  logic [15:0] prev_oi [NI];
  logic [MAXW-1:0] rec_d [NI][$];
  int rec_i [NI][$];
  int cyc = 0;

  function automatic int exp_gap(input int i, input int p);
`ifdef DCOLLIDE_LOADER_PREFETCH_EN
    return int'(LA[i]) + 2;
`else
    return int'(LA[i]) + 2 + (((p % int'(WA[i])) == 0) ? 1 : 0);
`endif
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      md[i]  = 32'hBAD0_0000;
      eom[i] = 1'b1;
      if (since[i] >= int'(LA[i]) - 1) begin
        eom[i] = (addr[i] >= nmem);
        if (addr[i] < nmem) md[i] = mem[addr[i][5:0]];
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        addr[i] <= 0; primed[i] <= 1'b0; since[i] <= 100; pulses[i] <= 0;
        gap_bad[i] <= 0; hold_err[i] <= 0; stall_pulse[i] <= 0; prev_stall[i] <= 1'b0;
        rec_d[i].delete(); rec_i[i].delete();
      end else begin
        if (fdr[i]) begin
          if (primed[i]) addr[i] <= addr[i] + 1;
          else primed[i] <= 1'b1;
          since[i] <= 0;
          if (pulses[i] > 0 && ((cyc - last_pulse[i]) < int'(LA[i]) + 2 ||
              (chk_gap && (cyc - last_pulse[i]) != exp_gap(i, pulses[i]))))
            gap_bad[i] <= gap_bad[i] + 1;
          pulses[i] <= pulses[i] + 1;
          last_pulse[i] <= cyc;
        end else if (since[i] < 100) begin
          since[i] <= since[i] + 1;
        end
        if (ov[i] && obj_ready) begin
          rec_d[i].push_back(od[i]);
          rec_i[i].push_back(int'(oi[i]));
        end
        if (prev_stall[i] && !(ov[i] && od[i] == prev_od[i] && oi[i] == prev_oi[i]))
          hold_err[i] <= hold_err[i] + 1;
        if (fdr[i] && ov[i] && !obj_ready) stall_pulse[i] <= stall_pulse[i] + 1;
        prev_stall[i] <= ov[i] && !obj_ready;
        prev_od[i] <= od[i];
        prev_oi[i] <= oi[i];
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [MAXW-1:0] act,
                     input logic [MAXW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", nm, inst, act, exp);
    end
  endtask

  // pct >= 0: random obj_ready with that percentage; pct < 0: stall for 20 cycles.
  task automatic do_run(input int n, input int pct);
    int scnt;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; obj_ready = 1'b0; nmem = n; chk_gap = (pct == 100);
    repeat (2) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    scnt = -1;
    for (int c = 0; c < 4000 && dn != 3'b111; c++) begin
      if (pct >= 0) obj_ready = ($urandom_range(0, 99) < pct);
      else begin
        if (scnt < 0 && ov[0]) scnt = 0;
        else if (scnt >= 0 && scnt < 20) scnt++;
        obj_ready = (scnt >= 20);
      end
      @(negedge clk);
    end
    chk("done_all", 0, MAXW'(dn), MAXW'(3'b111));
  endtask

  task automatic check_run(input int n, input logic [2:0][7:0] nrec, input logic [2:0] part);
    logic [MAXW-1:0] e;
    int w;
    for (int i = 0; i < NI; i++) begin
      w = int'(WA[i]);
      chk("rec_count", i, MAXW'(rec_d[i].size()), MAXW'(nrec[i]));
      for (int k = 0; k < rec_d[i].size() && k < int'(nrec[i]); k++) begin
        e = '0;
        for (int j = 0; j < w; j++) e[j*32 +: 32] = mem[k*w + j];
        chk("rec_data", i, rec_d[i][k], e);
        chk("rec_index", i, MAXW'(rec_i[i][k]), MAXW'(k & 16'hFFFF));
      end
      chk("partial_obj", i, MAXW'(pobj[i]), MAXW'(part[i]));
      chk("done", i, MAXW'(dn[i]), MAXW'(1));
      chk("pulse_count", i, MAXW'(pulses[i]), MAXW'(n + 1));
      chk("pulse_gaps", i, MAXW'(gap_bad[i]), '0);
      chk("stall_hold", i, MAXW'(hold_err[i]), '0);
`ifndef DCOLLIDE_LOADER_PREFETCH_EN
      chk("stall_pulses", i, MAXW'(stall_pulse[i]), '0);
`endif
    end
  endtask

  typedef struct packed {
    logic [7:0]       n;
    logic [7:0]       pct;
    logic [2:0][7:0]  nrec;   // {inst2, inst1, inst0}
    logic [2:0]       part;   // bit i = instance i
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n;
    logic [2:0][7:0] rn;
    logic [2:0] rp;
    tbl[0] = '{n: 8'd5,  pct: 8'd100, nrec: {8'd1, 8'd1, 8'd1}, part: 3'b101};
    tbl[1] = '{n: 8'd8,  pct: 8'd100, nrec: {8'd2, 8'd1, 8'd2}, part: 3'b010};
    tbl[2] = '{n: 8'd0,  pct: 8'd100, nrec: {8'd0, 8'd0, 8'd0}, part: 3'b000};
    tbl[3] = '{n: 8'd3,  pct: 8'd70,  nrec: {8'd0, 8'd0, 8'd0}, part: 3'b111};
    tbl[4] = '{n: 8'd10, pct: 8'd50,  nrec: {8'd2, 8'd2, 8'd2}, part: 3'b101};
    tbl[5] = '{n: 8'd20, pct: 8'd35,  nrec: {8'd5, 8'd4, 8'd5}, part: 3'b000};
    tbl[6] = '{n: 8'd16, pct: 8'd100, nrec: {8'd4, 8'd3, 8'd4}, part: 3'b010};

    for (int k = 0; k < 64; k++) mem[k] = 32'hA0 + k;
    for (int t = 0; t < 7; t++) begin
      do_run(int'(tbl[t].n), int'(tbl[t].pct));
      check_run(int'(tbl[t].n), tbl[t].nrec, tbl[t].part);
    end

    // Output stalled for 20 cycles after the first record appears.
    for (int k = 0; k < 64; k++) mem[k] = 32'h5000_0000 + (k << 4);
    do_run(12, -1);
    check_run(12, {8'd3, 8'd2, 8'd3}, 3'b010);
`ifdef DCOLLIDE_LOADER_PREFETCH_EN
    chk("stall_prefetch_pulses", 0, MAXW'(stall_pulse[0]), MAXW'(4));
`else
    chk("stall_no_pulses", 0, MAXW'(stall_pulse[0]), '0);
`endif

    // Reset while instance 0 waits on its third word.
    for (int k = 0; k < 64; k++) mem[k] = 32'hC000_0000 + k;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; obj_ready = 1'b1; nmem = 9; chk_gap = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    for (int c = 0; c < 200 && pulses[0] < 3; c++) @(negedge clk);
    chk("third_pulse", 0, MAXW'(pulses[0]), MAXW'(3));
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_fdr", i, MAXW'(fdr[i]), '0);
      chk("rst_valid", i, MAXW'(ov[i]), '0);
      chk("rst_partial", i, MAXW'(pobj[i]), '0);
      chk("rst_done", i, MAXW'(dn[i]), '0);
      chk("rst_data", i, od[i], '0);
      chk("rst_index", i, MAXW'(oi[i]), '0);
    end
    do_run(9, 100);
    check_run(9, {8'd2, 8'd1, 8'd2}, 3'b111);

    // Randomized memory images and handshake pressure.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(0, 24);
      for (int k = 0; k < 64; k++) mem[k] = $urandom;
      for (int i = 0; i < NI; i++) begin
        rn[i] = 8'(n / int'(WA[i]));
        rp[i] = (n % int'(WA[i])) != 0;
      end
      do_run(n, $urandom_range(20, 100));
      check_run(n, rn, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
